// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data memory initiator.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RMW_WR = 1'b1;

endpackage

// File: rtl/mem_access_unit_lane_merge_extract.sv
// Byte/half lane extraction with sign/zero extension for loads,
// and lane insertion into a read word for sub-word stores.
module lane_merge_extract
    import mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merged_data
);

    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] byte_word;
    logic [31:0] half_word;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Big-endian puts byte offset 0 in the most significant lane.
    assign byte_lane = BIG_ENDIAN ? ~offset : offset;
    assign half_lane = BIG_ENDIAN ? ~offset[1] : offset[1];
    assign byte_sh   = {byte_lane, 3'b000};
    assign half_sh   = {half_lane, 4'b0000};
    assign byte_word = rdata >> byte_sh;
    assign half_word = rdata >> half_sh;
    assign byte_val  = byte_word[7:0];
    assign half_val  = half_word[15:0];

    always_comb begin
        load_data   = rdata;
        merged_data = wdata;
        case (size)
            SIZE_BYTE: begin
                load_data   = {{24{~is_unsigned & byte_val[7]}}, byte_val};
                merged_data = (rdata & ~(32'h0000_00FF << byte_sh))
                            | ({24'h0, wdata[7:0]} << byte_sh);
            end
            SIZE_HALF: begin
                load_data   = {{16{~is_unsigned & half_val[15]}}, half_val};
                merged_data = (rdata & ~(32'h0000_FFFF << half_sh))
                            | ({16'h0, wdata[15:0]} << half_sh);
            end
            default: begin
                load_data   = rdata;
                merged_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: loads, word stores and read-modify-write sub-word
// stores against a word-organised data memory with combinational read.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req_valid,
    input  logic              Req_write,
    input  logic [1:0]        Req_size,
    input  logic              Req_unsigned,
    input  logic [31:0]       Req_addr,
    input  logic [31:0]       Req_wdata,
    output logic              Stall,
    output logic              Load_valid,
    output logic [31:0]       Load_data,
    output logic              Misaligned,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic              Mem_MemRead,
    output logic              Mem_MemWrite,
    output logic [31:0]       Mem_Write_data,
    input  logic [31:0]       Mem_Read_data
);

    // Handshake: a request (Req_valid=1) is taken in IDLE. While Stall is high the
    // requester holds every Req_* input stable; a cycle with Stall low retires it.
    logic [0:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       merge_q;
    logic              load_valid_q;
    logic [31:0]       load_data_q;
    logic              misaligned_q;

    logic              aligned;
    logic              req_go;
    logic              sub_store;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       ext_data;
    logic [31:0]       merged_data;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^Req_addr[31:ADDR_W+2];
    assign word_addr        = Req_addr[ADDR_W+1:2];

    always_comb begin
        case (Req_size)
            SIZE_BYTE: aligned = 1'b1;
            SIZE_HALF: aligned = ~Req_addr[0];
            SIZE_WORD: aligned = (Req_addr[1:0] == 2'b00);
            default:   aligned = 1'b0;
        endcase
    end

    assign req_go    = (state == IDLE) && Req_valid && aligned;
    assign sub_store = req_go && Req_write && (Req_size != SIZE_WORD);

    lane_merge_extract #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .rdata       (Mem_Read_data),
        .wdata       (Req_wdata),
        .offset      (Req_addr[1:0]),
        .size        (Req_size),
        .is_unsigned (Req_unsigned),
        .load_data   (ext_data),
        .merged_data (merged_data)
    );

    // Reset also gates the memory strobes so an in-flight RMW write is dropped.
    always_comb begin
        Mem_Address    = '0;
        Mem_MemRead    = 1'b0;
        Mem_MemWrite   = 1'b0;
        Mem_Write_data = '0;
        Stall          = 1'b0;
        if (Rst_n) begin
            if (state == RMW_WR) begin
                Mem_Address    = addr_q;
                Mem_MemWrite   = 1'b1;
                Mem_Write_data = merge_q;
            end else if (req_go) begin
                Mem_Address = word_addr;
                if (!Req_write) begin
                    Mem_MemRead = 1'b1;
                end else if (Req_size == SIZE_WORD) begin
                    Mem_MemWrite   = 1'b1;
                    Mem_Write_data = Req_wdata;
                end else begin
                    Mem_MemRead = 1'b1;
                    Stall       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            merge_q      <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            load_valid_q <= req_go && !Req_write;
            misaligned_q <= (state == IDLE) && Req_valid && !aligned;
            if (req_go && !Req_write) begin
                load_data_q <= ext_data;
            end
            case (state)
                IDLE: begin
                    if (sub_store) begin
                        state   <= RMW_WR;
                        addr_q  <= word_addr;
                        merge_q <= merged_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Load_valid = load_valid_q;
    assign Load_data  = load_data_q;
    assign Misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and a load scoreboard.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int ADDR_W = 13;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              misaligned;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] exp_q[$];
    int n_tests;
    int n_fail;

    mem_access_unit #(
        .ADDR_W     (ADDR_W),
        .BIG_ENDIAN (1'b1)
    ) dut (
        .Clk            (clk),
        .Rst_n          (rst_n),
        .Req_valid      (req_valid),
        .Req_write      (req_write),
        .Req_size       (req_size),
        .Req_unsigned   (req_unsigned),
        .Req_addr       (req_addr),
        .Req_wdata      (req_wdata),
        .Stall          (stall),
        .Load_valid     (load_valid),
        .Load_data      (load_data),
        .Misaligned     (misaligned),
        .Mem_Address    (mem_address),
        .Mem_MemRead    (mem_read),
        .Mem_MemWrite   (mem_write),
        .Mem_Write_data (mem_write_data),
        .Mem_Read_data  (mem_read_data)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data memory model
    assign mem_read_data = mem[mem_address];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard and invariants
    always @(negedge clk) begin
        if (rst_n) begin
            check("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
            check("lv_mis_exclusive", {31'b0, load_valid & misaligned}, 32'd0);
            if (load_valid) begin
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL load_unexpected: observed %h expected none", load_data);
                end
                if (exp_q.size() != 0) check("load_data", load_data, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = d;
    endtask

    task automatic clear();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                           input logic [31:0] exp);
        drive(1'b0, sz, uns, a, 32'h0);
        exp_q.push_back(exp);
        @(negedge clk);
        check("load_memread", {31'b0, mem_read}, 32'd1);
        check("load_addr", {19'b0, mem_address}, {19'b0, a[ADDR_W+1:2]});
        check("load_stall", {31'b0, stall}, 32'd0);
        step();
        clear();
        @(negedge clk);
        check("load_valid_lat1", {31'b0, load_valid}, 32'd1);
        step();
    endtask

    task automatic do_store_word(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, SIZE_WORD, 1'b0, a, d);
        @(negedge clk);
        check("sw_memwrite", {31'b0, mem_write}, 32'd1);
        check("sw_wdata", mem_write_data, d);
        check("sw_stall", {31'b0, stall}, 32'd0);
        step();
        clear();
    endtask

    task automatic do_store_sub(input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] merged);
        drive(1'b1, sz, 1'b0, a, d);
        @(negedge clk);
        check("rmw_rd_stall", {31'b0, stall}, 32'd1);
        check("rmw_rd_memread", {31'b0, mem_read}, 32'd1);
        step();
        @(negedge clk);
        check("rmw_wr_stall", {31'b0, stall}, 32'd0);
        check("rmw_wr_memwrite", {31'b0, mem_write}, 32'd1);
        check("rmw_wr_addr", {19'b0, mem_address}, {19'b0, a[ADDR_W+1:2]});
        check("rmw_wr_data", mem_write_data, merged);
        step();
        clear();
    endtask

    task automatic do_misaligned(input logic w, input logic [1:0] sz, input logic [31:0] a);
        drive(w, sz, 1'b0, a, 32'hCAFE_F00D);
        @(negedge clk);
        check("mis_no_enables", {30'b0, mem_read, mem_write}, 32'd0);
        check("mis_stall", {31'b0, stall}, 32'd0);
        step();
        clear();
        @(negedge clk);
        check("mis_pulse", {31'b0, misaligned}, 32'd1);
        check("mis_no_load", {31'b0, load_valid}, 32'd0);
        step();
        @(negedge clk);
        check("mis_single", {31'b0, misaligned}, 32'd0);
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = SIZE_WORD;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;

        // reset state
        @(negedge clk);
        check("rst_outputs", {29'b0, stall, load_valid, misaligned}, 32'd0);
        check("rst_enables", {30'b0, mem_read, mem_write}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_mem_addr", {19'b0, mem_address}, 32'd0);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("idle_enables", {29'b0, mem_read, mem_write, stall}, 32'd0);
        step();

        // 1: word store then load
        do_store_word(32'h0000_0010, 32'hDEAD_BEEF);
        check("sw_mem", mem[4], 32'hDEAD_BEEF);
        do_load(SIZE_WORD, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);

        // 2: byte store, big-endian lane
        mem[8] = 32'h1122_3344;
        do_store_sub(SIZE_BYTE, 32'h0000_0021, 32'h0000_00AB, 32'h11AB_3344);
        @(negedge clk);
        check("sb_mem", mem[8], 32'h11AB_3344);
        step();

        // 3: load extension, high address bits ignored
        do_load(SIZE_BYTE, 1'b0, 32'h0000_0021, 32'hFFFF_FFAB);
        do_load(SIZE_BYTE, 1'b1, 32'h0000_0021, 32'h0000_00AB);
        do_load(SIZE_HALF, 1'b0, 32'h0000_0022, 32'h0000_3344);
        do_load(SIZE_HALF, 1'b0, 32'h0000_0020, 32'h0000_11AB);
        do_load(SIZE_BYTE, 1'b0, 32'h0000_0023, 32'h0000_0044);
        do_load(SIZE_WORD, 1'b0, 32'hF000_8020, 32'h11AB_3344);
        mem[9] = 32'h8765_4321;
        do_load(SIZE_HALF, 1'b0, 32'h0000_0024, 32'hFFFF_8765);
        do_load(SIZE_HALF, 1'b1, 32'h0000_0024, 32'h0000_8765);

        // 4: misaligned requests leave memory untouched
        do_misaligned(1'b0, SIZE_WORD, 32'h0000_0022);
        do_misaligned(1'b1, SIZE_HALF, 32'h0000_0023);
        do_misaligned(1'b1, 2'b11,     32'h0000_0020);
        check("mis_mem", mem[8], 32'h11AB_3344);

        // 5: reset during RMW_WR aborts the write
        mem[12] = 32'h0102_0304;
        drive(1'b1, SIZE_HALF, 1'b0, 32'h0000_0030, 32'h0000_BEEF);
        @(negedge clk);
        check("rst_rmw_stall", {31'b0, stall}, 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        check("rst_rmw_ctrl", {27'b0, stall, load_valid, misaligned, mem_read, mem_write}, 32'd0);
        check("rst_rmw_wdata", mem_write_data, 32'd0);
        check("rst_rmw_addr", {19'b0, mem_address}, 32'd0);
        clear();
        @(negedge clk);
        check("rst_rmw_mem", mem[12], 32'h0102_0304);
        rst_n = 1'b1;
        step();
        do_load(SIZE_WORD, 1'b0, 32'h0000_0030, 32'h0102_0304);

        // 6: back-to-back sub-word store then load of the same word
        mem[16] = 32'hAABB_CCDD;
        do_store_sub(SIZE_HALF, 32'h0000_0040, 32'h1234_BEEF, 32'hBEEF_CCDD);
        do_load(SIZE_WORD, 1'b0, 32'h0000_0040, 32'hBEEF_CCDD);
        do_store_sub(SIZE_BYTE, 32'h0000_0043, 32'h0000_0077, 32'hBEEF_CC77);
        do_load(SIZE_HALF, 1'b1, 32'h0000_0042, 32'h0000_CC77);

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
